// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiplier / restoring divider with HI/LO result registers.
// One bit per cycle for WIDTH cycles, then a sign-correction cycle; results appear 33 cycles after start.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W = WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           div_q, div_d;
    logic           sa_q, sa_d;
    logic           sb_q, sb_d;
    logic [W-1:0]   mb_q, mb_d;
    logic [2*W-1:0] p_q, p_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum, rem_sh, rem_diff;
    logic           rem_ge;
    logic [2*W-1:0] mul_nx, div_nx, prod;
    logic [W-1:0]   quo, rem;

    always_comb begin
        mag_a    = (op[0] && A[W-1]) ? -A : A;
        mag_b    = (op[0] && B[W-1]) ? -B : B;
        // Multiply: multiplier sits in the low half and is consumed LSB first.
        mul_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, mb_q} : '0);
        mul_nx   = {mul_sum, p_q[W-1:1]};
        // Divide: partial remainder in the high half, dividend bits shift in from the low half.
        rem_sh   = {p_q[2*W-1:W], p_q[W-1]};
        rem_diff = rem_sh - {1'b0, mb_q};
        rem_ge   = rem_sh >= {1'b0, mb_q};
        div_nx   = {rem_ge ? rem_diff[W-1:0] : rem_sh[W-1:0], p_q[W-2:0], rem_ge};
        prod     = (sa_q ^ sb_q) ? -p_q : p_q;
        quo      = (mb_q == '0) ? '1 : ((sa_q ^ sb_q) ? -p_q[W-1:0] : p_q[W-1:0]);
        rem      = sa_q ? -p_q[2*W-1:W] : p_q[2*W-1:W];
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        mb_d     = mb_q;
        p_d      = p_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                hi_d = hi_we ? wdata : hi_q;
                lo_d = lo_we ? wdata : lo_q;
                if (start) begin
                    div_d   = op[1];
                    sa_d    = op[0] & A[W-1];
                    sb_d    = op[0] & B[W-1];
                    mb_d    = op[1] ? mag_b : mag_a;
                    p_d     = {{W{1'b0}}, op[1] ? mag_a : mag_b};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                p_d     = div_q ? div_nx : mul_nx;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(W - 1)) ? SIGN : CALC;
            end
            SIGN: begin
                hi_d    = div_q ? rem : prod[2*W-1:W];
                lo_d    = div_q ? quo : prod[W-1:0];
                cnt_d   = '0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            mb_q    <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            mb_q    <= mb_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed bench for mul_div_unit with a queue scoreboard of expected {hi,lo}.
// Expected results come from 64-bit integer arithmetic, special-casing divide by zero.
module tb_mul_div_unit;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb_q[$];

    mul_div_unit dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = o[0] ? longint'($signed(a)) : longint'({32'b0, a});
        sb = o[0] ? longint'($signed(b)) : longint'({32'b0, b});
        if (!o[1]) return 64'(sa * sb);
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // mode 0: plain; 1: second start + MTHI at E10 must be ignored; 2: MTLO in the start cycle
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int mode);
        int lat;
        bit got;
        logic [31:0] h0;
        logic [63:0] exp;
        @(negedge CLK);
        start = 1'b1; op = o; A = a; B = b;
        if (mode == 2) begin lo_we = 1'b1; wdata = 32'h5A5A_0F0F; end
        sb_q.push_back(model(o, a, b));
        @(negedge CLK);
        start = 1'b0; lo_we = 1'b0; A = $urandom; B = $urandom; op = ~o;
        check({tag, "_busy_e0"}, 64'(busy), 64'd1);
        if (mode == 2) check({tag, "_lo_wr_with_start"}, 64'(lo), 64'h5A5A_0F0F);
        h0 = hi;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            if (mode == 1 && lat == 9) begin
                start = 1'b1; op = 2'b00; A = 32'd9; B = 32'd9; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            @(negedge CLK);
            lat++;
            if (mode == 1 && lat == 10) begin
                start = 1'b0; hi_we = 1'b0;
            end
            if (mode == 1 && lat == 11) check({tag, "_hi_we_busy"}, 64'(hi), 64'(h0));
            if (lat == 16) check({tag, "_busy_mid"}, 64'(busy), 64'd1);
            got = done;
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        check({tag, "_hilo"}, {hi, lo}, exp);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge CLK);
        check({tag, "_done_clr"}, 64'(done), 64'd0);
        if (mode == 1) begin
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge CLK);
                got = got | done;
            end
            check({tag, "_no_second_done"}, 64'(got), 64'd0);
        end
    endtask

    initial begin
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        check("multu_ff_model", model(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        run_op("multu_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 0);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0);
        run_op("divu_by0", 2'b10, 32'h0000_1234, 32'd0, 0);
        run_op("div_by0_neg", 2'b11, 32'hFFFF_FFF0, 32'd0, 0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mult_mix", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        run_op("div_rem_sign", 2'b11, 32'd17, 32'hFFFF_FFFB, 0);
        run_op("divu_big", 2'b10, 32'hF000_0001, 32'h0000_0003, 0);
        @(negedge CLK);
        lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge CLK);
        lo_we = 1'b0;
        check("mtlo_idle", 64'(lo), 64'hA5A5_A5A5);
        hi_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge CLK);
        hi_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'h0BAD_F00D);
        run_op("busy_ignore", 2'b00, 32'd1000, 32'd3000, 1);
        run_op("mtlo_start", 2'b01, 32'hFFFF_FFFF, 32'd7, 2);
        run_op("pre_reset", 2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        @(negedge CLK);
        start = 1'b1; op = 2'b00; A = 32'hFFFF; B = 32'hFFFF;
        @(negedge CLK);
        start = 1'b0;
        repeat (14) @(negedge CLK);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        run_op("multu_after_rst", 2'b00, 32'd3, 32'd4, 0);
        check("multu_after_rst_lo", 64'(lo), 64'd12);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit beside the ALU in the multi-cycle datapath.
- Takes operands from the ADR/BDR delay-register outputs.
- Holds a 64-bit result in HI/LO registers, which the writeback mux reads like ALU results.
- The control unit starts an operation, stalls its FSM while busy is high, and resumes when done pulses. This adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support without lengthening the ALU path.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset; active-high, asynchronous.
- start  input  1  begin operation; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  input  WIDTH  multiplicand/dividend (from ADR).
- B  input  WIDTH  multiplier/divisor (from BDR).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated.
- hi  output  WIDTH  HI register (product high half / remainder).
- lo  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (async, RST=1): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, all working registers 0.
- Reset mid-operation aborts; HI/LO return to 0.
- All outputs are registered.
- States: IDLE, CALC, SIGN.
- IDLE:
  - On start=1 at edge E0, latch op and operand signs.
  - Latch magnitudes: absolute values for signed ops, raw values otherwise.
  - Clear counter and accumulator; go to CALC; busy=1 after E0.
- CALC:
  - One iteration per cycle for WIDTH cycles (edges E1..E32); counter increments each edge.
  - Multiply: shift-add, 1 bit per cycle.
  - Divide: restoring, 1 quotient bit per cycle.
  - When counter reaches WIDTH-1, go to SIGN.
- SIGN (edge E33):
  - Apply sign correction and write hi/lo.
  - Set done=1 and busy=0; go to IDLE.
  - done returns to 0 at E34.
- Total latency: hi/lo valid and done=1 exactly 33 cycles after the start edge.
- Signed results:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- Division by zero (DIV or DIVU): full latency still taken; hi=A (original), lo=all ones. No trap.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy=1 is ignored: no restart, no queue.
- hi_we/lo_we:
  - In IDLE: write wdata at the next edge. If start is asserted in the same cycle, the write lands and the operation is also accepted; the operation result overwrites at E33.
  - While busy: writes are ignored.
- A and B are sampled only at E0. Changes during CALC have no effect.
- hi/lo hold their values between operations.

Test Plan:
- MULTU: A=0xFFFFFFFF, B=0xFFFFFFFF, start at E0 -> busy=1 over E1..E32; at E33 done=1, hi=0xFFFFFFFE, lo=0x00000001; done=0 at E34.
- MULT: A=0xFFFFFFFD (-3), B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 at E33.
- DIV: A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU: A=100, B=7 -> lo=14, hi=2.
- DIVU: A=0x1234, B=0 -> at E33 hi=0x00001234, lo=0xFFFFFFFF, done=1.
- Busy behaviour:
  - Second start at E10 with different operands -> ignored; first result appears at E33 and no second done follows.
  - hi_we=1 at E10 -> hi unaffected.
  - In IDLE, lo_we=1 with wdata=0xA5A5A5A5 -> lo=0xA5A5A5A5 next cycle.
- Reset mid-operation: RST pulsed at E15 (asynchronously, mid-cycle) -> busy, done, hi, lo go to 0 immediately; after release, a new MULTU 3*4 gives lo=12 33 cycles after its start.
